mem_bus_arbiter: RTL and testbench

- Shares one SRAM-like memory port between the IF fetch request and the MEM load/store request.
- Generates the stallreq_from_if and stallreq_from_mem inputs consumed by the datapath's hazard unit.
- Data access has fixed priority over fetch. Each returned word is buffered until the whole pipeline advances.
- At most one transaction is outstanding on the bus. An instruction fetch killed by a pipeline flush is drained and discarded.

---
 rtl/mem_bus_arbiter.sv | 161 ++++++++++++++++
 tb/tb_mem_bus_arbiter.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_bus_arbiter.sv
// Arbitrates one SRAM-like bus between instruction fetch and data access, with result buffering.
// Optional ARB_PERF_CNT_EN adds saturating per-requester stall-cycle counters.
module mem_bus_arbiter #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              inst_req,
    input  logic [ADDR_W-1:0] inst_addr,
    output logic [DATA_W-1:0] inst_rdata,
    output logic              inst_stall,
    input  logic              data_req,
    input  logic              data_we,
    input  logic [ADDR_W-1:0] data_addr,
    input  logic [DATA_W-1:0] data_wdata,
    input  logic [3:0]        data_sel,
    input  logic [1:0]        data_size,
    output logic [DATA_W-1:0] data_rdata,
    output logic              data_stall,
    input  logic              pipe_stall,
    input  logic              flush,
    output logic              bus_req,
    output logic              bus_wr,
    output logic [1:0]        bus_size,
    output logic [3:0]        bus_wstrb,
    output logic [ADDR_W-1:0] bus_addr,
    output logic [DATA_W-1:0] bus_wdata,
    input  logic              bus_addr_ok,
    input  logic              bus_data_ok,
    input  logic [DATA_W-1:0] bus_rdata
`ifdef ARB_PERF_CNT_EN
    ,
    output logic [31:0]       inst_wait_cnt,
    output logic [31:0]       data_wait_cnt
`endif
);

    typedef enum logic [2:0] {
        IDLE,
        I_ADDR,
        I_DATA,
        D_ADDR,
        D_DATA
    } state_t;

    state_t state, state_n;
    logic   inst_buf_valid;
    logic   data_buf_valid;
    logic   cancel;
    logic   data_wr_q;
    logic   inst_done;
    logic   data_done;
    logic   inst_keep;

    assign inst_done  = (state == I_DATA) && bus_data_ok;
    assign data_done  = (state == D_DATA) && bus_data_ok;
    // A flush arriving together with data_ok discards that response as well.
    assign inst_keep  = inst_done && !cancel && !flush;

    assign inst_stall = inst_req && !inst_buf_valid;
    assign data_stall = data_req && !data_buf_valid;

    always_comb begin
        state_n   = state;
        bus_req   = 1'b0;
        bus_wr    = 1'b0;
        bus_size  = 2'd0;
        bus_wstrb = '0;
        bus_addr  = '0;
        bus_wdata = '0;
        case (state)
            IDLE: begin
                if (data_req && !data_buf_valid)
                    state_n = D_ADDR;
                else if (inst_req && !inst_buf_valid && !flush)
                    state_n = I_ADDR;
            end
            I_ADDR: begin
                bus_req  = 1'b1;
                bus_addr = inst_addr;
                bus_size = 2'd2;
                if (bus_addr_ok)
                    state_n = I_DATA;
            end
            I_DATA: begin
                if (bus_data_ok)
                    state_n = IDLE;
            end
            D_ADDR: begin
                bus_req   = 1'b1;
                bus_wr    = data_we;
                bus_size  = data_size;
                bus_wstrb = data_we ? data_sel : 4'b0000;
                bus_addr  = data_addr;
                bus_wdata = data_wdata;
                if (bus_addr_ok)
                    state_n = D_DATA;
            end
            D_DATA: begin
                if (bus_data_ok)
                    state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state          <= IDLE;
            inst_buf_valid <= 1'b0;
            data_buf_valid <= 1'b0;
            cancel         <= 1'b0;
            data_wr_q      <= 1'b0;
            inst_rdata     <= '0;
            data_rdata     <= '0;
        end else begin
            state <= state_n;

            if (inst_done)
                cancel <= 1'b0;
            else if (flush && (state == I_ADDR || state == I_DATA))
                cancel <= 1'b1;

            // Write direction is latched at acceptance so the response is classified correctly.
            if (state == D_ADDR && bus_addr_ok)
                data_wr_q <= data_we;

            if (inst_keep)
                inst_buf_valid <= 1'b1;
            else if (flush || !pipe_stall)
                inst_buf_valid <= 1'b0;

            if (inst_keep)
                inst_rdata <= bus_rdata;

            if (data_done)
                data_buf_valid <= 1'b1;
            else if (!pipe_stall)
                data_buf_valid <= 1'b0;

            if (data_done && !data_wr_q)
                data_rdata <= bus_rdata;
        end
    end

`ifdef ARB_PERF_CNT_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            inst_wait_cnt <= '0;
            data_wait_cnt <= '0;
        end else begin
            if (inst_stall && inst_wait_cnt != 32'hFFFF_FFFF)
                inst_wait_cnt <= inst_wait_cnt + 32'd1;
            if (data_stall && data_wait_cnt != 32'hFFFF_FFFF)
                data_wait_cnt <= data_wait_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed self-checking bench for mem_bus_arbiter: cycle table plus flush/hold/reset sequences.
module tb_mem_bus_arbiter;

    logic        clk;
    logic        rst;
    logic        inst_req;
    logic [31:0] inst_addr;
    logic [31:0] inst_rdata;
    logic        inst_stall;
    logic        data_req;
    logic        data_we;
    logic [31:0] data_addr;
    logic [31:0] data_wdata;
    logic [3:0]  data_sel;
    logic [1:0]  data_size;
    logic [31:0] data_rdata;
    logic        data_stall;
    logic        pipe_stall;
    logic        flush;
    logic        bus_req;
    logic        bus_wr;
    logic [1:0]  bus_size;
    logic [3:0]  bus_wstrb;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic        bus_addr_ok;
    logic        bus_data_ok;
    logic [31:0] bus_rdata;
`ifdef ARB_PERF_CNT_EN
    logic [31:0] inst_wait_cnt;
    logic [31:0] data_wait_cnt;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    mem_bus_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk(clk), .rst(rst),
        .inst_req(inst_req), .inst_addr(inst_addr), .inst_rdata(inst_rdata), .inst_stall(inst_stall),
        .data_req(data_req), .data_we(data_we), .data_addr(data_addr), .data_wdata(data_wdata),
        .data_sel(data_sel), .data_size(data_size), .data_rdata(data_rdata), .data_stall(data_stall),
        .pipe_stall(pipe_stall), .flush(flush),
        .bus_req(bus_req), .bus_wr(bus_wr), .bus_size(bus_size), .bus_wstrb(bus_wstrb),
        .bus_addr(bus_addr), .bus_wdata(bus_wdata),
        .bus_addr_ok(bus_addr_ok), .bus_data_ok(bus_data_ok), .bus_rdata(bus_rdata)
`ifdef ARB_PERF_CNT_EN
        , .inst_wait_cnt(inst_wait_cnt), .data_wait_cnt(data_wait_cnt)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic        ireq;
        logic [31:0] iaddr;
        logic        dreq;
        logic        dwe;
        logic [31:0] daddr;
        logic [31:0] dwdata;
        logic [3:0]  dsel;
        logic [1:0]  dsize;
        logic        ps;
        logic        fl;
        logic        aok;
        logic        dok;
        logic [31:0] rdata;
        logic        e_breq;
        logic        e_bwr;
        logic [3:0]  e_wstrb;
        logic [1:0]  e_bsize;
        logic [31:0] e_baddr;
        logic [31:0] e_bwdata;
        logic        e_is;
        logic        e_ds;
        logic [31:0] e_ir;
        logic [31:0] e_dr;
    } vec_t;

    localparam logic        L  = 1'b0;
    localparam logic        H  = 1'b1;
    localparam logic [31:0] Z  = 32'h0000_0000;
    localparam logic [31:0] PA = 32'hBFC0_0000;
    localparam logic [31:0] PB = 32'hBFC0_0004;
    localparam logic [31:0] LA = 32'h8000_1000;
    localparam logic [31:0] SA = 32'h8000_2000;
    localparam logic [31:0] SD = 32'h0000_BEEF;
    localparam logic [31:0] R1 = 32'h2408_0001;
    localparam logic [31:0] R2 = 32'h1111_2222;
    localparam logic [31:0] R3 = 32'h3333_4444;
    localparam logic [31:0] RX = 32'hA5A5_A5A5;

    vec_t vecs[18];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s @%0t: got %h, expected %h", name, $time, act, exp);
        end
    endtask

    task automatic idle_inputs();
        inst_req = 1'b0; inst_addr = '0; data_req = 1'b0; data_we = 1'b0;
        data_addr = '0; data_wdata = '0; data_sel = '0; data_size = '0;
        pipe_stall = 1'b1; flush = 1'b0; bus_addr_ok = 1'b0; bus_data_ok = 1'b0; bus_rdata = '0;
    endtask

    // Advance to just after the next rising edge, where inputs are changed.
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        vecs[0]  = '{H,PA,L,L,Z,Z,4'h0,2'd0, H,L,L,L,Z,  L,L,4'h0,2'd0,Z,Z,   H,L,Z,Z};
        vecs[1]  = '{H,PA,L,L,Z,Z,4'h0,2'd0, H,L,H,L,Z,  H,L,4'h0,2'd2,PA,Z,  H,L,Z,Z};
        vecs[2]  = '{H,PA,L,L,Z,Z,4'h0,2'd0, H,L,L,H,R1, L,L,4'h0,2'd0,Z,Z,   H,L,Z,Z};
        vecs[3]  = '{H,PA,L,L,Z,Z,4'h0,2'd0, L,L,L,L,Z,  L,L,4'h0,2'd0,Z,Z,   L,L,R1,Z};
        vecs[4]  = '{L,PA,L,L,Z,Z,4'h0,2'd0, L,L,L,L,Z,  L,L,4'h0,2'd0,Z,Z,   L,L,R1,Z};
        vecs[5]  = '{H,PB,H,L,LA,Z,4'hF,2'd2, H,L,L,L,Z,  L,L,4'h0,2'd0,Z,Z,  H,H,R1,Z};
        vecs[6]  = '{H,PB,H,L,LA,Z,4'hF,2'd2, H,L,H,L,Z,  H,L,4'h0,2'd2,LA,Z, H,H,R1,Z};
        vecs[7]  = '{H,PB,H,L,LA,Z,4'hF,2'd2, H,L,L,H,R2, L,L,4'h0,2'd0,Z,Z,  H,H,R1,Z};
        vecs[8]  = '{H,PB,H,L,LA,Z,4'hF,2'd2, H,L,L,L,Z,  L,L,4'h0,2'd0,Z,Z,  H,L,R1,R2};
        vecs[9]  = '{H,PB,H,L,LA,Z,4'hF,2'd2, H,L,H,L,Z,  H,L,4'h0,2'd2,PB,Z, H,L,R1,R2};
        vecs[10] = '{H,PB,H,L,LA,Z,4'hF,2'd2, H,L,L,H,R3, L,L,4'h0,2'd0,Z,Z,  H,L,R1,R2};
        vecs[11] = '{H,PB,H,L,LA,Z,4'hF,2'd2, L,L,L,L,Z,  L,L,4'h0,2'd0,Z,Z,  L,L,R3,R2};
        vecs[12] = '{L,PB,L,L,LA,Z,4'hF,2'd2, L,L,L,L,Z,  L,L,4'h0,2'd0,Z,Z,  L,L,R3,R2};
        vecs[13] = '{L,PB,H,H,SA,SD,4'h3,2'd1, H,L,L,L,Z,  L,L,4'h0,2'd0,Z,Z,   L,H,R3,R2};
        vecs[14] = '{L,PB,H,H,SA,SD,4'h3,2'd1, H,L,H,L,Z,  H,H,4'h3,2'd1,SA,SD, L,H,R3,R2};
        vecs[15] = '{L,PB,H,H,SA,SD,4'h3,2'd1, H,L,L,H,RX, L,L,4'h0,2'd0,Z,Z,   L,H,R3,R2};
        vecs[16] = '{L,PB,H,H,SA,SD,4'h3,2'd1, L,L,L,L,Z,  L,L,4'h0,2'd0,Z,Z,   L,L,R3,R2};
        vecs[17] = '{L,PB,L,H,SA,SD,4'h3,2'd1, L,L,L,L,Z,  L,L,4'h0,2'd0,Z,Z,   L,L,R3,R2};

        rst = 1'b0;
        idle_inputs();
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_bus_req", {31'd0, bus_req}, 32'd0);
        chk("rst_inst_rdata", inst_rdata, 32'd0);
        chk("rst_data_rdata", data_rdata, 32'd0);
        chk("rst_stalls", {30'd0, inst_stall, data_stall}, 32'd0);
        rst = 1'b1;

        for (int i = 0; i < 18; i++) begin
            next_cycle();
            inst_req = vecs[i].ireq;   inst_addr = vecs[i].iaddr;
            data_req = vecs[i].dreq;   data_we = vecs[i].dwe;
            data_addr = vecs[i].daddr; data_wdata = vecs[i].dwdata;
            data_sel = vecs[i].dsel;   data_size = vecs[i].dsize;
            pipe_stall = vecs[i].ps;   flush = vecs[i].fl;
            bus_addr_ok = vecs[i].aok; bus_data_ok = vecs[i].dok; bus_rdata = vecs[i].rdata;
            @(negedge clk);
            chk($sformatf("v%0d_bus_req", i), {31'd0, bus_req}, {31'd0, vecs[i].e_breq});
            chk($sformatf("v%0d_bus_wr", i), {31'd0, bus_wr}, {31'd0, vecs[i].e_bwr});
            chk($sformatf("v%0d_bus_wstrb", i), {28'd0, bus_wstrb}, {28'd0, vecs[i].e_wstrb});
            chk($sformatf("v%0d_bus_size", i), {30'd0, bus_size}, {30'd0, vecs[i].e_bsize});
            chk($sformatf("v%0d_bus_addr", i), bus_addr, vecs[i].e_baddr);
            chk($sformatf("v%0d_bus_wdata", i), bus_wdata, vecs[i].e_bwdata);
            chk($sformatf("v%0d_inst_stall", i), {31'd0, inst_stall}, {31'd0, vecs[i].e_is});
            chk($sformatf("v%0d_data_stall", i), {31'd0, data_stall}, {31'd0, vecs[i].e_ds});
            chk($sformatf("v%0d_inst_rdata", i), inst_rdata, vecs[i].e_ir);
            chk($sformatf("v%0d_data_rdata", i), data_rdata, vecs[i].e_dr);
        end

        // Flush while the fetch is in its data phase; the late response must be dropped.
        next_cycle();
        idle_inputs();
        inst_req = 1'b1; inst_addr = 32'hBFC0_0100;
        @(negedge clk);
        chk("fl_idle_bus_req", {31'd0, bus_req}, 32'd0);
        next_cycle();
        bus_addr_ok = 1'b1;
        @(negedge clk);
        chk("fl_iaddr_bus_req", {31'd0, bus_req}, 32'd1);
        chk("fl_iaddr_bus_addr", bus_addr, 32'hBFC0_0100);
        next_cycle();
        bus_addr_ok = 1'b0; flush = 1'b1; inst_addr = 32'hBFC0_0200;
        @(negedge clk);
        chk("fl_idata_bus_req", {31'd0, bus_req}, 32'd0);
        next_cycle();
        flush = 1'b0; bus_data_ok = 1'b1; bus_rdata = 32'hDEAD_BEEF;
        @(negedge clk);
        chk("fl_dok_inst_stall", {31'd0, inst_stall}, 32'd1);
        next_cycle();
        bus_data_ok = 1'b0; bus_rdata = '0;
        @(negedge clk);
        chk("fl_after_inst_stall", {31'd0, inst_stall}, 32'd1);
        chk("fl_after_bus_req", {31'd0, bus_req}, 32'd0);
        next_cycle();
        bus_addr_ok = 1'b1;
        @(negedge clk);
        chk("fl_refetch_bus_req", {31'd0, bus_req}, 32'd1);
        chk("fl_refetch_addr", bus_addr, 32'hBFC0_0200);
        next_cycle();
        bus_addr_ok = 1'b0; bus_data_ok = 1'b1; bus_rdata = 32'h1234_5678;
        @(negedge clk);
        chk("fl_refetch_data_bus_req", {31'd0, bus_req}, 32'd0);

        // Fetched word held while a load is still stalling the pipeline.
        next_cycle();
        bus_data_ok = 1'b0; bus_rdata = '0;
        data_req = 1'b1; data_addr = 32'h8000_3000; data_sel = 4'hF; data_size = 2'd2;
        @(negedge clk);
        chk("hold_inst_stall0", {31'd0, inst_stall}, 32'd0);
        chk("hold_inst_rdata", inst_rdata, 32'h1234_5678);
        chk("hold_data_stall0", {31'd0, data_stall}, 32'd1);
        next_cycle();
        bus_addr_ok = 1'b1;
        @(negedge clk);
        chk("hold_daddr_bus_addr", bus_addr, 32'h8000_3000);
        chk("hold_inst_stall1", {31'd0, inst_stall}, 32'd0);
        next_cycle();
        bus_addr_ok = 1'b0; bus_data_ok = 1'b1; bus_rdata = 32'h5555_6666;
        @(negedge clk);
        chk("hold_ddata_bus_req", {31'd0, bus_req}, 32'd0);
        next_cycle();
        bus_data_ok = 1'b0; bus_rdata = '0;
        @(negedge clk);
        chk("hold_both_stalls", {30'd0, inst_stall, data_stall}, 32'd0);
        chk("hold_data_rdata", data_rdata, 32'h5555_6666);
        chk("hold_no_fetch", {31'd0, bus_req}, 32'd0);
        next_cycle();
        pipe_stall = 1'b0;
        @(negedge clk);
        chk("hold_still_no_fetch", {31'd0, bus_req}, 32'd0);
        next_cycle();
        pipe_stall = 1'b1;
        @(negedge clk);
        chk("clr_inst_stall", {31'd0, inst_stall}, 32'd1);
        chk("clr_data_stall", {31'd0, data_stall}, 32'd1);

        // Asynchronous reset while the load is on the bus.
        next_cycle();
        @(negedge clk);
        chk("rst_pre_bus_req", {31'd0, bus_req}, 32'd1);
        #1 rst = 1'b0;
        #1;
        chk("arst_bus_req", {31'd0, bus_req}, 32'd0);
        chk("arst_data_stall", {31'd0, data_stall}, 32'd1);
        chk("arst_inst_rdata", inst_rdata, 32'd0);
        chk("arst_data_rdata", data_rdata, 32'd0);
`ifdef ARB_PERF_CNT_EN
        chk("arst_inst_cnt", inst_wait_cnt, 32'd0);
        chk("arst_data_cnt", data_wait_cnt, 32'd0);
`endif
        next_cycle();
        rst = 1'b1;
        inst_req = 1'b0; data_req = 1'b0;
        bus_data_ok = 1'b1; bus_rdata = 32'h9999_9999;
        @(negedge clk);
        chk("late_rsp_bus_req", {31'd0, bus_req}, 32'd0);
        next_cycle();
        bus_data_ok = 1'b0; bus_rdata = '0;
        @(negedge clk);
        chk("late_rsp_data_rdata", data_rdata, 32'd0);
        chk("late_rsp_inst_rdata", inst_rdata, 32'd0);
        chk("late_rsp_stalls", {30'd0, inst_stall, data_stall}, 32'd0);

`ifdef ARB_PERF_CNT_EN
        next_cycle();
        inst_req = 1'b1; inst_addr = 32'hBFC0_0300;
        repeat (3) next_cycle();
        @(negedge clk);
        chk("cnt_inst_wait", inst_wait_cnt, 32'd3);
        chk("cnt_data_wait", data_wait_cnt, 32'd0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
